// File: rtl/cdc_fifo_src_sched_pkg.sv
// Shared types and helpers for the round-robin source scheduler in front of a gray-code CDC FIFO.
package cdc_fifo_src_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_MAX_BURST = 8;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_fifo_src_sched_if.sv
// Requester-side and FIFO-side handshake bundle of the source scheduler.
interface cdc_fifo_src_sched_if #(
  parameter int unsigned NUM_REQ = cdc_fifo_src_sched_pkg::DEF_NUM_REQ,
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned IDX_W   = cdc_fifo_src_sched_pkg::idx_width(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           fifo_valid;
  logic [DATA_W-1:0]              fifo_data;
  logic [IDX_W-1:0]               fifo_idx;
  logic                           fifo_last;
  logic                           fifo_ready;

  modport master (
    output req_valid, req_data, req_last, fifo_ready,
    input  req_ready, fifo_valid, fifo_data, fifo_idx, fifo_last
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_ready,
    output req_ready, fifo_valid, fifo_data, fifo_idx, fifo_last
  );

endinterface

// File: rtl/cdc_fifo_src_sched_rr_pick.sv
// Combinational rotate-priority pick: first valid requester at or above ptr_i, wrapping.
module cdc_fifo_src_sched_rr_pick
  import cdc_fifo_src_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return sum[IDX_W-1:0];
  endfunction

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_o && valid_i[wrap_idx(ptr_i, k)]) begin
        any_o = 1'b1;
        idx_o = wrap_idx(ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_src_sched.sv
// Round-robin scheduler sharing one CDC FIFO source port among NUM_REQ requesters.
// Data/index/last are a pure mux; only the arbitration state is registered.
module cdc_fifo_src_sched
  import cdc_fifo_src_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned DATA_W      = 1,
  parameter bit          LOCK_PACKET = 1'b1,
  parameter int unsigned MAX_BURST   = DEF_MAX_BURST
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cdc_fifo_src_sched_if.slave  bus,
  output logic                 busy_o
);

  localparam int unsigned IdxWidth = idx_width(NUM_REQ);
  localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);

  typedef logic [IdxWidth-1:0] idx_t;
  typedef logic [CntWidth-1:0] cnt_t;

  state_e state_q, state_d;
  idx_t   rr_ptr_q, rr_ptr_d;
  idx_t   lock_idx_q, lock_idx_d;
  cnt_t   beat_cnt_q, beat_cnt_d;

  idx_t   pick_idx, sel_idx, next_ptr;
  logic   pick_any, sel_valid, sel_last, hs, cap_hit, grant_done;

  cdc_fifo_src_sched_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxWidth)
  ) u_rr_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Once locked the grant is pinned so a stalled beat keeps its index.
  always_comb begin
    sel_idx    = (state_q == LOCKED) ? lock_idx_q : pick_idx;
    sel_valid  = (state_q == LOCKED) ? bus.req_valid[lock_idx_q] : pick_any;
    sel_last   = bus.req_last[sel_idx];
    hs         = sel_valid && bus.fifo_ready;
    cap_hit    = (LOCK_PACKET == 1'b0) && (beat_cnt_q + cnt_t'(1) == cnt_t'(MAX_BURST));
    grant_done = hs && (sel_last || cap_hit);
    next_ptr   = (sel_idx == idx_t'(NUM_REQ - 1)) ? '0 : sel_idx + idx_t'(1);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_done) begin
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (sel_valid) begin
          state_d    = LOCKED;
          lock_idx_d = sel_idx;
          if (hs && (LOCK_PACKET == 1'b0)) beat_cnt_d = beat_cnt_q + cnt_t'(1);
        end
      end
      LOCKED: begin
        if (grant_done) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (hs && (LOCK_PACKET == 1'b0)) begin
          beat_cnt_d = beat_cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Every output is held at zero while reset is asserted.
  always_comb begin
    bus.fifo_valid = sel_valid && !rst_i;
    bus.fifo_data  = rst_i ? '0 : bus.req_data[sel_idx];
    bus.fifo_idx   = rst_i ? '0 : sel_idx;
    bus.fifo_last  = sel_last && !rst_i;
    bus.req_ready  = '0;
    if (bus.fifo_ready && !rst_i) bus.req_ready[sel_idx] = 1'b1;
    busy_o         = (state_q == LOCKED) && !rst_i;
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) $onehot0(bus.req_ready));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.fifo_valid && !bus.fifo_ready) |=> ($stable(bus.fifo_idx) && $stable(bus.fifo_data)));
`endif

endmodule

// File: tb/tb_cdc_fifo_src_sched.sv
// Directed bench: requester queues feed the scheduler, a scoreboard holds the expected beat order.
module tb_cdc_fifo_src_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]         rv, rl;
  logic [NR-1:0][DW-1:0] rd;
  logic                  rdy;
  logic                  use_b;
  logic [NR-1:0]         gap;
  logic                  busy_a, busy_b;

  logic          o_valid, o_last, o_busy;
  logic [1:0]    o_idx;
  logic [DW-1:0] o_data;
  logic [NR-1:0] o_ready;

  logic [8:0] pq [NR][$];
  exp_t       sb [$];
  int         checks = 0;
  int         errors = 0;

  cdc_fifo_src_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) ifa ();
  cdc_fifo_src_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) ifb ();

  assign ifa.req_valid  = use_b ? '0 : rv;
  assign ifa.req_data   = rd;
  assign ifa.req_last   = rl;
  assign ifa.fifo_ready = rdy;
  assign ifb.req_valid  = use_b ? rv : '0;
  assign ifb.req_data   = rd;
  assign ifb.req_last   = rl;
  assign ifb.fifo_ready = rdy;

  assign o_valid = use_b ? ifb.fifo_valid : ifa.fifo_valid;
  assign o_last  = use_b ? ifb.fifo_last  : ifa.fifo_last;
  assign o_idx   = use_b ? ifb.fifo_idx   : ifa.fifo_idx;
  assign o_data  = use_b ? ifb.fifo_data  : ifa.fifo_data;
  assign o_ready = use_b ? ifb.req_ready  : ifa.req_ready;
  assign o_busy  = use_b ? busy_b         : busy_a;

  cdc_fifo_src_sched #(.NUM_REQ(NR), .DATA_W(DW), .LOCK_PACKET(1'b1), .MAX_BURST(8)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (ifa), .busy_o (busy_a)
  );

  cdc_fifo_src_sched #(.NUM_REQ(NR), .DATA_W(DW), .LOCK_PACKET(1'b0), .MAX_BURST(2)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (ifb), .busy_o (busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (pq[i].size() > 0 && !gap[i]) begin
        h     = pq[i][0];
        rv[i] = 1'b1;
        rd[i] = h[7:0];
        rl[i] = h[8];
      end else begin
        rv[i] = 1'b0;
        rd[i] = '0;
        rl[i] = 1'b0;
      end
    end
  endtask

  task automatic pkt(input int r, input int n, input logic [7:0] base);
    for (int b = 0; b < n; b++) pq[r].push_back({(b == n - 1), base + 8'(b)});
  endtask

  task automatic expb(input int r, input logic [7:0] d, input logic last);
    sb.push_back('{idx: 2'(r), data: d, last: last});
  endtask

  // One cycle: score any handshake mid-cycle, retire the accepted beat after the edge.
  task automatic step();
    exp_t e;
    int   pend;
    pend = -1;
    @(negedge clk);
    if (o_valid && rdy) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed=beat_idx_%0d expected=no_beat", o_idx);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("idx",       32'(o_idx),   32'(e.idx));
        chk("data",      32'(o_data),  32'(e.data));
        chk("last",      32'(o_last),  32'(e.last));
        chk("req_ready", 32'(o_ready), 32'(1) << e.idx);
      end
      pend = int'(o_idx);
    end
    @(posedge clk);
    #1;
    if (pend >= 0 && pq[pend].size() > 0) void'(pq[pend].pop_front());
    drive();
  endtask

  task automatic run(input int max_cycles);
    for (int c = 0; c < max_cycles && sb.size() > 0; c++) step();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d_pending expected=0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; use_b = 1'b0; gap = '0;
    rv = '0; rl = '0; rd = '0;
    // Fairness packets are already presented while reset is held.
    pkt(0, 1, 8'h10); pkt(0, 1, 8'h14);
    pkt(1, 1, 8'h11); pkt(1, 1, 8'h15);
    pkt(2, 1, 8'h12);
    pkt(3, 1, 8'h13);
    drive();
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_idx",   32'(o_idx),   0);
    chk("rst_data",  32'(o_data),  0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness
    expb(0, 8'h10, 1); expb(1, 8'h11, 1); expb(2, 8'h12, 1);
    expb(3, 8'h13, 1); expb(0, 8'h14, 1); expb(1, 8'h15, 1);
    run(20);

    // Packet lock: req1 alone for its first beat, then competitors appear
    pkt(1, 5, 8'h20); drive();
    for (int b = 0; b < 5; b++) expb(1, 8'h20 + 8'(b), (b == 4));
    step();
    pkt(0, 1, 8'h30); pkt(2, 1, 8'h32); drive();
    chk("lock_busy", 32'(o_busy), 1);
    expb(2, 8'h32, 1); expb(0, 8'h30, 1);
    run(20);

    // Backpressure on req3, req1 joins during the stall
    rdy = 1'b0;
    pkt(3, 1, 8'h40); drive();
    @(negedge clk);
    chk("bp_valid", 32'(o_valid), 1);
    chk("bp_idx",   32'(o_idx),   3);
    chk("bp_data",  32'(o_data),  32'h40);
    chk("bp_ready", 32'(o_ready), 0);
    @(posedge clk); #1;
    pkt(1, 1, 8'h41); drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_idx_hold",  32'(o_idx),   3);
      chk("bp_data_hold", 32'(o_data),  32'h40);
      chk("bp_ready_low", 32'(o_ready), 0);
      chk("bp_busy",      32'(o_busy),  1);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    expb(3, 8'h40, 1); expb(1, 8'h41, 1);
    run(10);

    // Wrap and valid gap inside a req3 packet
    pkt(3, 3, 8'h50); drive();
    expb(3, 8'h50, 0);
    step();
    gap[3] = 1'b1;
    pkt(0, 1, 8'h60); drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("gap_valid", 32'(o_valid), 0);
      chk("gap_idx",   32'(o_idx),   3);
      chk("gap_busy",  32'(o_busy),  1);
      @(posedge clk); #1;
    end
    gap[3] = 1'b0; drive();
    expb(3, 8'h51, 0); expb(3, 8'h52, 1); expb(0, 8'h60, 1);
    run(10);

    // Reset during beat 3 of a req2 packet
    pkt(2, 5, 8'h70); drive();
    expb(2, 8'h70, 0); expb(2, 8'h71, 0);
    step(); step();
    rst = 1'b1;
    pkt(0, 1, 8'h80); drive();
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_ready", 32'(o_ready), 0);
    chk("mid_rst_busy",  32'(o_busy),  0);
    chk("mid_rst_idx",   32'(o_idx),   0);
    chk("mid_rst_data",  32'(o_data),  0);
    chk("mid_rst_last",  32'(o_last),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    expb(0, 8'h80, 1);
    expb(2, 8'h72, 0); expb(2, 8'h73, 0); expb(2, 8'h74, 1);
    run(20);

    // Burst cap of two beats on the unlocked instance
    use_b = 1'b1;
    pkt(0, 6, 8'h90); pkt(1, 6, 8'hA0); drive();
    for (int g = 0; g < 3; g++) begin
      expb(0, 8'h90 + 8'(2 * g), 0); expb(0, 8'h91 + 8'(2 * g), (g == 2));
      expb(1, 8'hA0 + 8'(2 * g), 0); expb(1, 8'hA1 + 8'(2 * g), (g == 2));
    end
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
